ram_programmer: RTL and testbench

RAM_PROGRAMMER -- requirements
Module: ram_programmer

---
 rtl/ram_programmer.sv | 163 ++++++++++++++++
 tb/tb_ram_programmer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_programmer.sv
// Purpose : loads a byte stream into an async SRAM in program mode; passes the
//           CPU address/read-enable straight through to the SRAM in run mode.
// Latency : 4 cycles per byte (IDLE accept, SETUP, STROBE, RECOVER); 5 with the VERIFY readback.
// Backpr. : in_ready is high only in program-mode IDLE; the loader holds in_valid/in_data until accepted.
//
// Ports:
//   clk, rst                 sole clock; asynchronous active-high reset
//   run_not_prog             1 = CPU owns SRAM, 0 = loader owns SRAM
//   in_valid/in_data/in_ready  loader byte handshake
//   mar_addr, cpu_ce_bar     CPU address and active-low read enable (run mode)
//   sram_addr/sram_wr_data/sram_ce_bar/sram_we_bar/sram_rd_data  SRAM pins
//   prog_done                every location has been written
//   prog_err                 sticky readback mismatch (readback build only)
//
// Build option: define RAM_PROG_VERIFY_EN to add a readback VERIFY cycle after each write.

module ram_programmer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_not_prog,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  input  logic                  cpu_ce_bar,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic                  sram_ce_bar,
  output logic                  sram_we_bar,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  output logic                  prog_done,
  output logic                  prog_err
);

`ifdef RAM_PROG_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, VERIFY, DONE} state_t;
  logic                  err_q;
`else
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;
`endif

  state_t                state;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  ce_q;
  logic                  we_q;

  // CPU owns the bus only once the FSM is parked in IDLE with run mode registered.
  logic run_pass;
  assign run_pass = (state == IDLE) && mode_q;

  // A run->program edge is recognised while parked (IDLE or DONE): mode_q is
  // still 1 and the input has already dropped.
  logic enter_prog;
  assign enter_prog = mode_q && !run_not_prog;

  logic last_addr;
  assign last_addr = (ptr == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 1'b1;
      ptr    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ce_q   <= 1'b1;
      we_q   <= 1'b1;
`ifdef RAM_PROG_VERIFY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      mode_q <= run_not_prog;
      case (state)
        IDLE: begin
          if (enter_prog) begin
            ptr    <= '0;
            done_q <= 1'b0;
`ifdef RAM_PROG_VERIFY_EN
            err_q  <= 1'b0;
`endif
          end else if (!mode_q && in_valid) begin
            data_q <= in_data;
            state  <= SETUP;
          end
        end
        SETUP: begin
          ce_q  <= 1'b0;
          we_q  <= 1'b0;
          state <= STROBE;
        end
        STROBE: begin
          ce_q  <= 1'b1;
          we_q  <= 1'b1;
          state <= RECOVER;
        end
`ifdef RAM_PROG_VERIFY_EN
        RECOVER: begin
          ce_q  <= 1'b0;   // read back the location just written
          state <= VERIFY;
        end
        VERIFY: begin
          ce_q <= 1'b1;
          if (sram_rd_data != data_q)
            err_q <= 1'b1;
          ptr <= ptr + 1'b1;
          if (last_addr) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= IDLE;
          end
        end
`else
        RECOVER: begin
          ptr <= ptr + 1'b1;   // wraps to 0 after the last location
          if (last_addr) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= IDLE;
          end
        end
`endif
        DONE: begin
          if (mode_q) begin
            state <= IDLE;
            if (!run_not_prog) begin
              ptr    <= '0;
              done_q <= 1'b0;
`ifdef RAM_PROG_VERIFY_EN
              err_q  <= 1'b0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes come straight from flops in program mode; only run-mode pass-through is combinational.
  assign sram_addr    = run_pass ? mar_addr   : ptr;
  assign sram_ce_bar  = run_pass ? cpu_ce_bar : ce_q;
  assign sram_we_bar  = run_pass ? 1'b1       : we_q;
  assign sram_wr_data = data_q;
  assign in_ready     = (state == IDLE) && !mode_q;
  assign prog_done    = done_q;

`ifdef RAM_PROG_VERIFY_EN
  assign prog_err = err_q;
`else
  assign prog_err = 1'b0;
  logic unused_rd;
  assign unused_rd = ^sram_rd_data;
`endif

endmodule

// File: tb/tb_ram_programmer.sv
// Purpose : self-checking bench for ram_programmer with a behavioural SRAM and write scoreboard.
// Latency : n/a (bench).
// Backpr. : loader driver holds in_valid/in_data until in_ready is seen.

module tb_ram_programmer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_not_prog;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] mar_addr;
  logic       cpu_ce_bar;
  logic [3:0] sram_addr;
  logic [7:0] sram_wr_data;
  logic       sram_ce_bar;
  logic       sram_we_bar;
  logic [7:0] sram_rd_data;
  logic       prog_done;
  logic       prog_err;

  always #5 clk = ~clk;

  ram_programmer dut (
    .clk(clk), .rst(rst), .run_not_prog(run_not_prog),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mar_addr(mar_addr), .cpu_ce_bar(cpu_ce_bar),
    .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
    .sram_ce_bar(sram_ce_bar), .sram_we_bar(sram_we_bar),
    .sram_rd_data(sram_rd_data), .prog_done(prog_done), .prog_err(prog_err)
  );

  int vec = 0;
  int err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural async SRAM: read when selected and not writing.
  logic [7:0] mem [16];
  logic       bad_rd = 1'b0;
  assign sram_rd_data = (!sram_ce_bar && sram_we_bar) ? (bad_rd ? 8'hFF : mem[sram_addr]) : 8'h00;

  // Scoreboard: expected {addr, data} pushed on accept, popped on each write strobe.
  logic [11:0] sb_q [$];
  logic [3:0]  exp_ptr = 4'd0;
  logic        prev_strobe = 1'b0;

  always @(negedge clk) begin
    logic        strobe;
    logic [11:0] e;
    if (rst) begin
      sb_q.delete();
      prev_strobe = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back({exp_ptr, in_data});
        exp_ptr = exp_ptr + 4'd1;
      end
      strobe = !sram_ce_bar && !sram_we_bar;
      if (strobe) begin
        chk("we_single_cycle", {31'd0, prev_strobe}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", {28'd0, sram_addr}, {28'd0, e[11:8]});
          chk("wr_data", {24'd0, sram_wr_data}, {24'd0, e[7:0]});
        end
        mem[sram_addr] = sram_wr_data;
      end
      prev_strobe = strobe;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge (FSM then in SETUP).
  task automatic send(input logic [7:0] d, input int gap);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = prog_done;
    end
    chk("prog_done_timeout", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drop into program mode from run mode; restart the expected address.
  task automatic enter_program();
    run_not_prog = 1'b1;
    cycles(3);
    run_not_prog = 1'b0;
    exp_ptr = 4'd0;
    cycles(2);
  endtask

  typedef struct {
    logic [3:0] mar;
    logic       ce;
    logic [3:0] e_addr;
    logic       e_ce;
    logic [7:0] e_rd;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] stream [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'd5,  1'b0, 4'd5,  1'b0, 8'h15};
    tbl[1] = '{4'd0,  1'b0, 4'd0,  1'b0, 8'h10};
    tbl[2] = '{4'd15, 1'b0, 4'd15, 1'b0, 8'h1F};
    tbl[3] = '{4'd9,  1'b1, 4'd9,  1'b1, 8'h00};
    tbl[4] = '{4'd5,  1'b1, 4'd5,  1'b1, 8'h00};
    tbl[5] = '{4'd3,  1'b0, 4'd3,  1'b0, 8'h13};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    rst = 1'b1; run_not_prog = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    mar_addr = 4'd0; cpu_ce_bar = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_prog_done", {31'd0, prog_done}, 32'd0);
    chk("rst_prog_err", {31'd0, prog_err}, 32'd0);
    chk("rst_we_bar", {31'd0, sram_we_bar}, 32'd1);
    chk("rst_ce_bar", {31'd0, sram_ce_bar}, 32'd1);
    chk("rst_wr_data", {24'd0, sram_wr_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full 16-byte stream, in_valid held high.
    enter_program();
    chk("prog_in_ready", {31'd0, in_ready}, 32'd1);
    for (int n = 0; n < 16; n++) send(8'h10 + 8'(n), 0);
    wait_done();
    in_valid = 1'b1; in_data = 8'hEE;   // ignored in DONE
    cycles(5);
    @(negedge clk);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    chk("done_held", {31'd0, prog_done}, 32'd1);
    in_valid = 1'b0;
    for (int n = 0; n < 16; n++) chk("mem_stream", {24'd0, mem[n]}, 32'h10 + n);

    // Run-mode pass-through table.
    @(posedge clk); #1;
    run_not_prog = 1'b1;
    cycles(3);
    for (int i = 0; i < 6; i++) begin
      mar_addr = tbl[i].mar; cpu_ce_bar = tbl[i].ce;
      @(negedge clk);
      chk("run_addr", {28'd0, sram_addr}, {28'd0, tbl[i].e_addr});
      chk("run_ce_bar", {31'd0, sram_ce_bar}, {31'd0, tbl[i].e_ce});
      chk("run_we_bar", {31'd0, sram_we_bar}, 32'd1);
      chk("run_in_ready", {31'd0, in_ready}, 32'd0);
      chk("run_rd_data", {24'd0, sram_rd_data}, {24'd0, tbl[i].e_rd});
      @(posedge clk); #1;
    end
    cpu_ce_bar = 1'b1;

    // Mode raised during SETUP of the byte at ptr 3.
    enter_program();
    chk("reentry_done_clr", {31'd0, prog_done}, 32'd0);
    send(8'h40, 0); send(8'h41, 1); send(8'h42, 0); send(8'h43, 2);
    run_not_prog = 1'b1;
    cycles(6);
    mar_addr = 4'd7; cpu_ce_bar = 1'b0;
    @(negedge clk);
    chk("midwr_pass_addr", {28'd0, sram_addr}, 32'd7);
    chk("midwr_pass_ce", {31'd0, sram_ce_bar}, 32'd0);
    chk("midwr_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midwr_mem3", {24'd0, mem[3]}, 32'h43);
    chk("midwr_mem4", {24'd0, mem[4]}, 32'h14);
    @(posedge clk); #1;
    cpu_ce_bar = 1'b1;
    run_not_prog = 1'b0; exp_ptr = 4'd0;
    cycles(2);
    send(8'h50, 0);
    cycles(6);
    chk("restart_mem0", {24'd0, mem[0]}, 32'h50);

    // Irregular in_valid gaps.
    enter_program();
    for (int n = 0; n < 16; n++) begin
      stream[n] = 8'($urandom);
      send(stream[n], int'($urandom_range(0, 7)));
    end
    wait_done();
    for (int n = 0; n < 16; n++) chk("mem_gappy", {24'd0, mem[n]}, {24'd0, stream[n]});

    // Reset in the middle of STROBE.
    enter_program();
    in_valid = 1'b1; in_data = 8'h77;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(negedge clk);
        hit = !sram_we_bar;
      end
      chk("strobe_reached", {31'd0, hit}, 32'd1);
    end
    #1 rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_mid_we_bar", {31'd0, sram_we_bar}, 32'd1);
    chk("rst_mid_ce_bar", {31'd0, sram_ce_bar}, 32'd1);
    chk("rst_mid_done", {31'd0, prog_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; exp_ptr = 4'd0;
    cycles(2);
    send(8'h66, 0);
    cycles(6);
    chk("post_rst_mem0", {24'd0, mem[0]}, 32'h66);
    chk("prog_err_default", {31'd0, prog_err}, 32'd0);

`ifdef RAM_PROG_VERIFY_EN
    enter_program();
    bad_rd = 1'b1;
    send(8'hA5, 0);
    cycles(6);
    bad_rd = 1'b0;
    chk("verify_err_set", {31'd0, prog_err}, 32'd1);
    send(8'h01, 0);
    cycles(6);
    chk("verify_err_sticky", {31'd0, prog_err}, 32'd1);
    run_not_prog = 1'b1;
    cycles(3);
    chk("verify_err_run", {31'd0, prog_err}, 32'd1);
    run_not_prog = 1'b0;
    cycles(2);
    chk("verify_err_clr", {31'd0, prog_err}, 32'd0);
`endif

    cycles(2);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
